mp_add_seq: RTL and testbench
=============================

Name: mp_add_seq

Overview:
- Multi-precision add/subtract sequencer built around one shared 16-bit ripple-adder slice (16+16+carry-in, 17-bit result).
- Accepts a WORDS×16-bit operand pair and walks the slice one limb per cycle, least-significant limb first, chaining the carry through a register.
- Returns the full-width result with carry/borrow, zero and signed-overflow flags over a valid/ready handshake.
- Sits between the arithmetic command front-end and the adder slice, so wide adds do not need a wide adder.

Parameters:
- LIMB_W, 16, width of one limb; equals the adder slice width.
- WORDS, 4, number of limbs per operand (≥1); total width N = LIMB_W*WORDS.
- CW, derived clog2(WORDS) (min 1), limb-counter width; not user-set.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; accepted when start & ready.
- ready  out  1  high only in IDLE.
- sub  in  1  0 = A+B, 1 = A−B; sampled on accept.
- cin  in  1  carry-in (add) or borrow-in (sub); sampled on accept.
- op_a  in  N  operand A; sampled on accept.
- op_b  in  N  operand B; sampled on accept.
- abort  in  1  synchronous cancel of an in-flight operation.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result when res_valid & res_ready.
- result  out  N  sum/difference.
- cout  out  1  carry-out (add) or borrow-out (sub).
- zero  out  1  result == 0.
- ovf  out  1  two's-complement signed overflow of the N-bit operation.

Behaviour:
- Reset (async assert, sync release): state=IDLE; ready=1; res_valid=0; result=0; cout=0; zero=0; ovf=0; limb counter=0; carry reg=0.
- FSM IDLE → RUN → DONE → IDLE.
- IDLE:
  - On start & ready, latch A, B' = sub ? ~op_b : op_b, and carry0 = sub ? ~cin : cin. Latch sub.
  - Clear the limb counter and go to RUN.
  - start while not IDLE is ignored; no queueing.
- RUN, limb k (0..WORDS-1):
  - Slice computes {c,s} = A[k] + B'[k] + carry.
  - Edge writes result[k]=s and carry=c.
  - Record the sign of A[k] and B'[k] at k=WORDS-1 for ovf.
  - k increments each cycle. After the edge that writes k=WORDS-1, go to DONE.
- DONE:
  - res_valid=1.
  - cout = sub ? ~carry : carry.
  - zero = (result==0).
  - ovf = (signA == signB') & (sign(result) != signA).
  - Outputs are stable while res_valid & ~res_ready (backpressure of any length).
  - On res_valid & res_ready: res_valid=0 next edge, go to IDLE, ready=1 that same next cycle.
  - result and flags hold their last values in IDLE.
- Latency: accept edge at cycle 0 → res_valid high in cycle WORDS+1 (one RUN cycle per limb). Throughput: one operation per WORDS+2 cycles with res_ready held high.
- abort: in RUN or DONE, the next state is IDLE and res_valid=0; partial result is discarded (result contents undefined but stable). abort in IDLE has no effect. abort together with start in IDLE: start wins.
- Reset mid-operation: immediately returns to the reset values; no result is produced.
- WORDS=1 is legal: single RUN cycle.
- Carry arithmetic is purely modulo 2^N. cout/ovf are the only wrap indicators.

Test Plan:
- Add wrap, WORDS=4: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0 → result=0, cout=1, zero=1, ovf=0; res_valid asserted exactly 5 cycles after the accept edge.
- Sub borrow: sub=1, A=0x0, B=0x1, cin=0 → result=0xFFFF_FFFF_FFFF_FFFF, cout=1, zero=0, ovf=0.
- Signed overflow and cin:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=0x0, cin=1 → result=0x8000_0000_0000_0000, ovf=1, cout=0.
  - sub=1, A=0x8000_0000_0000_0000, B=0x1 → ovf=1.
- Limb carry chain: A=0x0000_FFFF_0000_FFFF, B=0x0000_0001_0000_0001 → result=0x0001_0000_0001_0000, cout=0.
- Backpressure/start-ignore:
  - Hold res_ready=0 for 3 cycles and pulse start during RUN/DONE → outputs constant, ready=0, start ignored.
  - Then res_ready=1 → one-cycle handshake, ready=1 next cycle.
- Abort and reset:
  - abort at RUN limb 2 → IDLE next cycle, res_valid never asserts, next operation correct.
  - rst_n low mid-RUN → all outputs at reset values immediately (asynchronously).

Source files
------------

// File: rtl/mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : mp_add_seq
// Purpose  : Multi-precision add/subtract sequencer. An N-bit operand pair
//            (N = LIMB_W*WORDS) is pushed through a single LIMB_W-bit ripple
//            slice one limb per cycle, least-significant limb first. The carry
//            between limbs is chained through a register. The full result is
//            returned with carry/borrow, zero and signed-overflow flags.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            start/ready           - request handshake (ready only in IDLE)
//            sub, cin, op_a, op_b  - operation, carry/borrow-in, operands
//            abort                 - cancel an in-flight operation
//            res_valid/res_ready   - result handshake
//            result, cout, zero, ovf - N-bit result and flags
// Revision : 1.0 - initial release
// ============================================================================
module mp_add_seq #(
    parameter int LIMB_W = 16,
    parameter int WORDS  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      ready,
    input  logic                      sub,
    input  logic                      cin,
    input  logic [LIMB_W*WORDS-1:0]   op_a,
    input  logic [LIMB_W*WORDS-1:0]   op_b,
    input  logic                      abort,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [LIMB_W*WORDS-1:0]   result,
    output logic                      cout,
    output logic                      zero,
    output logic                      ovf
);

    localparam int N  = LIMB_W * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_DONE = 2'd2;
    localparam logic [CW-1:0] c_LAST = CW'(WORDS - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;

    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;        // already inverted for subtraction
    logic              r_carry;    // carry chained between limbs
    logic              r_sub;
    logic [CW-1:0]     r_cnt;      // limb currently in the slice
    logic [N-1:0]      r_result;
    logic              r_cout;
    logic              r_zero;
    logic              r_ovf;

    logic [LIMB_W-1:0] w_a_limb;
    logic [LIMB_W-1:0] w_b_limb;
    logic [LIMB_W:0]   w_sum;
    logic [N-1:0]      w_result_next;
    logic              w_last;

    // ------------------------------------------------------------------
    // Limb select and the shared ripple slice
    // ------------------------------------------------------------------
    always_comb begin
        w_a_limb      = '0;
        w_b_limb      = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_cnt == CW'(i)) begin
                w_a_limb = r_a[i*LIMB_W +: LIMB_W];
                w_b_limb = r_b[i*LIMB_W +: LIMB_W];
            end
        end
    end

    assign w_sum  = {1'b0, w_a_limb} + {1'b0, w_b_limb} + {{LIMB_W{1'b0}}, r_carry};
    assign w_last = (r_cnt == c_LAST);

    // Result with the current limb merged in; used for the limb write and,
    // on the last limb, for the zero flag so it covers the complete word.
    always_comb begin
        w_result_next = r_result;
        for (int i = 0; i < WORDS; i++) begin
            if (r_cnt == CW'(i)) begin
                w_result_next[i*LIMB_W +: LIMB_W] = w_sum[LIMB_W-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                // abort is ignored here, so start always wins
                if (start) begin
                    w_state_next = c_RUN;
                end
            end
            c_RUN: begin
                if (abort) begin
                    w_state_next = c_IDLE;
                end else if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            c_DONE: begin
                if (abort || res_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_sub    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        // Subtraction runs as A + ~B + ~borrow_in
                        r_a     <= op_a;
                        r_b     <= sub ? ~op_b : op_b;
                        r_carry <= sub ? ~cin : cin;
                        r_sub   <= sub;
                        r_cnt   <= '0;
                    end
                end
                c_RUN: begin
                    if (!abort) begin
                        r_result <= w_result_next;
                        r_carry  <= w_sum[LIMB_W];
                        r_cnt    <= r_cnt + CW'(1);
                        if (w_last) begin
                            // Top limb signs (B already inverted for sub)
                            // give the N-bit signed overflow directly.
                            r_cout <= r_sub ? ~w_sum[LIMB_W] : w_sum[LIMB_W];
                            r_zero <= (w_result_next == '0);
                            r_ovf  <= (w_a_limb[LIMB_W-1] == w_b_limb[LIMB_W-1]) &&
                                      (w_sum[LIMB_W-1] != w_a_limb[LIMB_W-1]);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = (r_state == c_IDLE);
    assign res_valid = (r_state == c_DONE);
    assign result    = r_result;
    assign cout      = r_cout;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_add_seq
// Purpose  : Self-checking bench for mp_add_seq (LIMB_W=16, WORDS=4) using a
//            plain-arithmetic reference model of the N-bit add/subtract.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_add_seq;

    localparam int LIMB_W = 16;
    localparam int WORDS  = 4;
    localparam int N      = LIMB_W * WORDS;
    localparam int LAT    = WORDS + 1;

    typedef struct packed {
        logic [N-1:0] r;
        logic         c;
        logic         z;
        logic         v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         ready;
    logic         sub;
    logic         cin;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic         abort;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    mp_add_seq #(
        .LIMB_W (LIMB_W),
        .WORDS  (WORDS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .sub       (sub),
        .cin       (cin),
        .op_a      (op_a),
        .op_b      (op_b),
        .abort     (abort),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .cout      (cout),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: whole-width two's-complement arithmetic
    function automatic exp_t model(input logic s, input logic ci,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N:0] full;
        exp_t       e;
        if (!s) full = {1'b0, a} + {1'b0, b} + (N+1)'(ci);
        else    full = {1'b0, a} - {1'b0, b} - (N+1)'(ci);
        e.r = full[N-1:0];
        e.c = full[N];
        e.z = (e.r == '0);
        if (!s) e.v = (a[N-1] == b[N-1]) && (e.r[N-1] != a[N-1]);
        else    e.v = (a[N-1] != b[N-1]) && (e.r[N-1] != a[N-1]);
        return e;
    endfunction

    function automatic logic [N-1:0] rand_op();
        logic [N-1:0] v;
        case ($urandom_range(0, 3))
            0:       v = {$urandom, $urandom};
            1:       v = '1;
            2:       v = {1'b1, {(N-1){1'b0}}} | N'($urandom_range(0, 3));
            default: v = {16'h7FFF, 16'hFFFF, 16'h0000, 16'(($urandom))};
        endcase
        return v;
    endfunction

    // Drives one operation (caller is just past a negedge), waits for the
    // result, holds res_ready low for 'hold' cycles, then handshakes.
    task automatic run_op(input logic s, input logic ci,
                          input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold, output exp_t got, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        sub = s; cin = ci; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (hold) @(negedge clk);
        got.r = result; got.c = cout; got.z = zero; got.v = ovf;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0;
        op_a = '0; op_b = '0; abort = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: ready=%b res_valid=%b, expected 1 0", ready, res_valid);
        end
        checks++;
        if (result !== '0 || cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: result=%h cout=%b zero=%b ovf=%b, expected 0 0 0 0",
                     result, cout, zero, ovf);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [N-1:0] ta [5];
        logic [N-1:0] tb [5];
        logic         ts [5];
        logic         tc [5];
        exp_t         e;
        exp_t         got;
        int           lat;
        ta[0] = 64'hFFFF_FFFF_FFFF_FFFF; tb[0] = 64'h1; ts[0] = 0; tc[0] = 0;
        ta[1] = 64'h0;                   tb[1] = 64'h1; ts[1] = 1; tc[1] = 0;
        ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'h0; ts[2] = 0; tc[2] = 1;
        ta[3] = 64'h8000_0000_0000_0000; tb[3] = 64'h1; ts[3] = 1; tc[3] = 0;
        ta[4] = 64'h0000_FFFF_0000_FFFF; tb[4] = 64'h0000_0001_0000_0001; ts[4] = 0; tc[4] = 0;
        for (int i = 0; i < 5; i++) begin
            e = model(ts[i], tc[i], ta[i], tb[i]);
            run_op(ts[i], tc[i], ta[i], tb[i], 0, got, lat);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL dir%0d: result=%h c=%b z=%b v=%b, expected %h %b %b %b",
                         i, got.r, got.c, got.z, got.v, e.r, e.c, e.z, e.v);
            end
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d cycles, expected %0d", i, lat, LAT);
            end
            checks++;
            if (ready !== 1'b1 || res_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_handshake: ready=%b res_valid=%b, expected 1 0",
                         i, ready, res_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         s;
        logic         ci;
        exp_t         e;
        exp_t         got;
        int           lat;
        for (int i = 0; i < 40; i++) begin
            a = rand_op(); b = rand_op();
            s = 1'($urandom); ci = 1'($urandom);
            e = model(s, ci, a, b);
            run_op(s, ci, a, b, int'($urandom_range(0, 2)), got, lat);
            checks++;
            if (got !== e || lat !== LAT) begin
                errors++;
                $display("FAIL rand%0d: result=%h c=%b z=%b v=%b lat=%0d, expected %h %b %b %b lat=%0d",
                         i, got.r, got.c, got.z, got.v, lat, e.r, e.c, e.z, e.v, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        int   acc[$];
        exp_t e;
        int   got_n;
        int   cyc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        got_n = 0;
        cyc   = 0;
        res_ready = 1'b1;
        while (got_n < 4 && cyc < 200) begin
            if (res_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra: result %h with no request outstanding", result);
                end else begin
                    e = q.pop_front();
                    if (result !== e.r || cout !== e.c || zero !== e.z || ovf !== e.v) begin
                        errors++;
                        $display("FAIL b2b%0d: result=%h c=%b z=%b v=%b, expected %h %b %b %b",
                                 got_n, result, cout, zero, ovf, e.r, e.c, e.z, e.v);
                    end
                end
                got_n++;
            end
            if (ready) begin
                if (acc.size() < 4) begin
                    a = rand_op(); b = rand_op();
                    sub = 1'($urandom); cin = 1'($urandom);
                    op_a = a; op_b = b; start = 1'b1;
                    q.push_back(model(sub, cin, a, b));
                    acc.push_back(cyc);
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (got_n != 4) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d results, expected 4", got_n);
        end
        for (int i = 0; i + 1 < acc.size(); i++) begin
            checks++;
            if (acc[i+1] - acc[i] != WORDS + 2) begin
                errors++;
                $display("FAIL b2b_spacing%0d: got %0d cycles, expected %0d",
                         i, acc[i+1] - acc[i], WORDS + 2);
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t snap;
        int   guard;
        e = model(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        sub = 1'b0; cin = 1'b0;
        op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        // start pulse during RUN must be ignored
        op_a = '1; op_b = '1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!res_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        snap.r = result; snap.c = cout; snap.z = zero; snap.v = ovf;
        checks++;
        if (snap !== e) begin
            errors++;
            $display("FAIL bp_value: result=%h c=%b z=%b v=%b, expected %h %b %b %b",
                     snap.r, snap.c, snap.z, snap.v, e.r, e.c, e.z, e.v);
        end
        for (int i = 0; i < 3; i++) begin
            op_a = {$urandom, $urandom}; start = 1'b1;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || ready !== 1'b0 || result !== e.r ||
                cout !== e.c || zero !== e.z || ovf !== e.v) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b result=%h, expected 1 0 %h",
                         i, res_valid, ready, result, e.r);
            end
        end
        start = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0 || result !== e.r) begin
            errors++;
            $display("FAIL bp_release: ready=%b valid=%b result=%h, expected 1 0 %h",
                     ready, res_valid, result, e.r);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0 || result !== e.r || cout !== e.c) begin
                errors++;
                $display("FAIL bp_idle%0d: valid=%b result=%h, expected 0 %h",
                         i, res_valid, result, e.r);
            end
        end
    endtask

    task automatic test_abort();
        exp_t e;
        exp_t got;
        int   lat;
        sub = 1'b0; cin = 1'b0; op_a = 64'h1; op_b = 64'h2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;              // limb 0 in slice
        @(negedge clk);            // limb 1
        @(negedge clk);            // limb 2
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_run: ready=%b valid=%b, expected 1 0", ready, res_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_novalid%0d: valid=%b, expected 0", i, res_valid);
            end
        end
        // abort with start in IDLE: start wins
        e = model(1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210);
        sub = 1'b1; cin = 1'b1;
        op_a = 64'h0123_4567_89AB_CDEF; op_b = 64'hFEDC_BA98_7654_3210;
        abort = 1'b1; start = 1'b1;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_start_wins: ready=%b, expected 0", ready);
        end
        lat = 1;
        while (!res_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== LAT || result !== e.r || cout !== e.c || zero !== e.z || ovf !== e.v) begin
            errors++;
            $display("FAIL abort_next: result=%h c=%b z=%b v=%b lat=%0d, expected %h %b %b %b lat=%0d",
                     result, cout, zero, ovf, lat, e.r, e.c, e.z, e.v, LAT);
        end
        // abort in DONE drops the result without a handshake
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: ready=%b valid=%b, expected 1 0", ready, res_valid);
        end
        e = model(1'b0, 1'b0, 64'hAAAA_0000_FFFF_0001, 64'h5555_FFFF_0001_FFFF);
        run_op(1'b0, 1'b0, 64'hAAAA_0000_FFFF_0001, 64'h5555_FFFF_0001_FFFF, 0, got, lat);
        checks++;
        if (got !== e || lat !== LAT) begin
            errors++;
            $display("FAIL abort_after: result=%h c=%b z=%b v=%b, expected %h %b %b %b",
                     got.r, got.c, got.z, got.v, e.r, e.c, e.z, e.v);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        exp_t got;
        int   lat;
        // leave a nonzero result with set flags so reset is visible
        run_op(1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 0, got, lat);
        sub = 1'b0; cin = 1'b0; op_a = 64'h3; op_b = 64'h4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || res_valid !== 1'b0 || result !== '0 ||
            cout !== 1'b0 || zero !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b valid=%b result=%h c=%b z=%b v=%b, expected 1 0 0 0 0 0",
                     ready, res_valid, result, cout, zero, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: valid=%b ready=%b, expected 0 1", res_valid, ready);
        end
        e = model(1'b1, 1'b0, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001);
        run_op(1'b1, 1'b0, 64'h0000_0000_0001_0000, 64'h0000_0000_0000_0001, 1, got, lat);
        checks++;
        if (got !== e || lat !== LAT) begin
            errors++;
            $display("FAIL reset_after: result=%h c=%b z=%b v=%b, expected %h %b %b %b",
                     got.r, got.c, got.z, got.v, e.r, e.c, e.z, e.v);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
